// File: rtl/ant.sv
// ant: PageRank worker hosting M of N graph nodes; remote ranks are fetched over request/response.
module ant #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*N-1:0]     adj,
  input  logic [N*WIDTH-1:0] nodeWeight,
  input  logic [1:0]         antId,
  input  logic [5:0]         query,
  input  logic [WIDTH+5:0]   response,
  output logic [5:0]         request,
  output logic [WIDTH-1:0]   reply,
  output logic [WIDTH-1:0]   node0Val
);

  localparam int unsigned AW = WIDTH + 6;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned IW = (ITERS < 1) ? 1 : $clog2(ITERS + 1);

  localparam logic [5:0]       NONE      = 6'h3F;
  localparam logic [5:0]       LAST_J    = 6'(N - 1);
  localparam logic [7:0]       M_C       = 8'(M);
  localparam logic [IW-1:0]    ITERS_C   = IW'(ITERS);
  localparam logic [SW-1:0]    FULL      = {1'b1, {WIDTH{1'b0}}};
  localparam logic [SW-1:0]    INIT_RAW  = FULL / SW'(N);
  localparam logic [WIDTH-1:0] INIT_RANK = INIT_RAW[WIDTH] ? {WIDTH{1'b1}} : INIT_RAW[WIDTH-1:0];

  typedef enum logic [1:0] {ACCUM = 2'd0, UPDATE = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [5:0]       j_q, j_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [5:0]       request_q, request_d;
  logic [WIDTH-1:0] reply_q, reply_d;
  logic [WIDTH-1:0] node0_q, node0_d;
  logic [WIDTH-1:0] rank_q [M];
  logic [WIDTH-1:0] rank_d [M];
  logic [AW-1:0]    acc_q  [M];
  logic [AW-1:0]    acc_d  [M];

  logic [7:0]       base_c, j_off_c, q_off_c;
  logic             j_local_c, q_local_c, add_en_c;
  logic [WIDTH-1:0] j_rank_c, q_rank_c, weight_c, src_rank_c, contrib_c;
  logic [M-1:0]     adj_col_c;

  // Locate j and query within the hosted range and select the operands they address.
  always_comb begin
    base_c    = 8'(antId) * M_C;
    j_off_c   = 8'(j_q) - base_c;
    q_off_c   = 8'(query) - base_c;
    j_local_c = (j_off_c < M_C);
    q_local_c = (query != NONE) && (q_off_c < M_C);
    j_rank_c  = '0;
    q_rank_c  = '0;
    weight_c  = '0;
    adj_col_c = '0;
    for (int k = 0; k < M; k++) begin
      if (j_off_c == 8'(k)) j_rank_c = rank_q[k];
      if (q_off_c == 8'(k)) q_rank_c = rank_q[k];
    end
    for (int c = 0; c < N; c++) begin
      if (j_q == 6'(c)) weight_c = nodeWeight[c*WIDTH +: WIDTH];
    end
    for (int k = 0; k < M; k++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if ((base_c + 8'(k) == 8'(r)) && (j_q == 6'(c))) adj_col_c[k] = adj[r*N + c];
        end
      end
    end
  end

  // Next state, accumulation of one source per cycle, commit and query service.
  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    iter_d     = iter_q;
    request_d  = request_q;
    node0_d    = node0_q;
    reply_d    = q_local_c ? q_rank_c : '0;
    src_rank_c = '0;
    add_en_c   = 1'b0;
    contrib_c  = '0;
    for (int k = 0; k < M; k++) begin
      rank_d[k] = rank_q[k];
      acc_d[k]  = acc_q[k];
    end
    case (state_q)
      ACCUM: begin
        if (j_local_c) begin
          src_rank_c = j_rank_c;
          add_en_c   = 1'b1;
        end else if (request_q == NONE) begin
          request_d = j_q;
        end else if (response[AW-1:WIDTH] == j_q) begin
          src_rank_c = response[WIDTH-1:0];
          add_en_c   = 1'b1;
          request_d  = NONE;
        end
        contrib_c = WIDTH'((PW'(src_rank_c) * PW'(weight_c)) >> WIDTH);
        if (add_en_c) begin
          for (int k = 0; k < M; k++) begin
            if (adj_col_c[k]) acc_d[k] = acc_q[k] + AW'(contrib_c);
          end
          if (j_q == LAST_J) state_d = UPDATE;
          else               j_d     = j_q + 6'd1;
        end
      end
      UPDATE: begin
        for (int k = 0; k < M; k++) begin
          rank_d[k] = (|acc_q[k][AW-1:WIDTH]) ? {WIDTH{1'b1}} : acc_q[k][WIDTH-1:0];
          acc_d[k]  = '0;
        end
        node0_d = (|acc_q[0][AW-1:WIDTH]) ? {WIDTH{1'b1}} : acc_q[0][WIDTH-1:0];
        j_d     = '0;
        iter_d  = iter_q + IW'(1);
        state_d = (iter_d == ITERS_C) ? DONE : ACCUM;
      end
      DONE: begin
      end
      default: state_d = ACCUM;
    endcase
  end

  // Registers; reset restarts from uniform ranks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      j_q       <= '0;
      iter_q    <= '0;
      request_q <= NONE;
      reply_q   <= '0;
      node0_q   <= INIT_RANK;
      for (int k = 0; k < M; k++) begin
        rank_q[k] <= INIT_RANK;
        acc_q[k]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      iter_q    <= iter_d;
      request_q <= request_d;
      reply_q   <= reply_d;
      node0_q   <= node0_d;
      for (int k = 0; k < M; k++) begin
        rank_q[k] <= rank_d[k];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

  assign request  = request_q;
  assign reply    = reply_q;
  assign node0Val = node0_q;

endmodule

// File: tb/tb_ant.sv
// tb_ant: scoreboard bench for ant; three instances cover all-local, remote-fetch and saturation cases.
module tb_ant;
  localparam int unsigned W = 16;
  localparam logic [5:0] NONE = 6'h3F;

  typedef struct {
    int           tag;
    int           d;
    int           ph;
    logic [W-1:0] n0;
    logic [W-1:0] rep;
    logic [5:0]   req;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, rst_b, rst_c;
  logic [15:0]    adj_a, adj_b;
  logic [3:0]     adj_c;
  logic [63:0]    wt_a, wt_b;
  logic [31:0]    wt_c;
  logic [1:0]     id_a, id_b, id_c;
  logic [5:0]     qry_a, qry_b, qry_c;
  logic [W+5:0]   rsp_a, rsp_b, rsp_c;
  logic [5:0]     req_a, req_b, req_c;
  logic [W-1:0]   rep_a, rep_b, rep_c;
  logic [W-1:0]   n0_a, n0_b, n0_c;

  ant #(.N(4), .M(4), .WIDTH(16), .ITERS(32)) u_a (
    .clk(clk), .reset(rst_a), .adj(adj_a), .nodeWeight(wt_a), .antId(id_a), .query(qry_a),
    .response(rsp_a), .request(req_a), .reply(rep_a), .node0Val(n0_a));
  ant #(.N(4), .M(2), .WIDTH(16), .ITERS(2)) u_b (
    .clk(clk), .reset(rst_b), .adj(adj_b), .nodeWeight(wt_b), .antId(id_b), .query(qry_b),
    .response(rsp_b), .request(req_b), .reply(rep_b), .node0Val(n0_b));
  ant #(.N(2), .M(2), .WIDTH(16), .ITERS(3)) u_c (
    .clk(clk), .reset(rst_c), .adj(adj_c), .nodeWeight(wt_c), .antId(id_c), .query(qry_c),
    .response(rsp_c), .request(req_c), .reply(rep_c), .node0Val(n0_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t         sb[$];
  int           dut, phase, cn, cm, cbase, citers;
  bit           m_adj [4][4];
  logic [W-1:0] m_w    [4];
  logic [W-1:0] m_rank [4];
  logic [W-1:0] m_rem  [4];
  logic [5:0]   cur_q;
  bit           finishing = 1'b0;
  bit           timed_out = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  function automatic bit is_local(input int idx);
    return (idx >= cbase) && (idx < cbase + cm);
  endfunction

  // floor(2^16/n), saturated; 0 for n == 0
  function automatic logic [W-1:0] recip(input int n);
    int unsigned v;
    if (n == 0) return '0;
    v = 32'd65536 / 32'(n);
    return (v > 32'd65535) ? 16'hFFFF : W'(v);
  endfunction

  function automatic logic [W-1:0] contrib(input logic [W-1:0] r, input logic [W-1:0] w);
    longint unsigned p;
    p = 64'(r) * 64'(w);
    return W'(p >> 16);
  endfunction

  // One PageRank iteration over the hosted nodes.
  task automatic commit_model();
    logic [W-1:0] nr [4];
    longint unsigned s;
    for (int i = 0; i < 4; i++) nr[i] = m_rank[i];
    for (int i = 0; i < cn; i++) begin
      if (!is_local(i)) continue;
      s = 0;
      for (int j = 0; j < cn; j++)
        if (m_adj[i][j]) s += 64'(contrib(is_local(j) ? m_rank[j] : m_rem[j], m_w[j]));
      nr[i] = (s > 64'd65535) ? 16'hFFFF : W'(s);
    end
    for (int i = 0; i < 4; i++) m_rank[i] = nr[i];
  endtask

  function automatic logic [5:0] rand_q();
    int r;
    r = $urandom_range(0, 7);
    if (r < cn) return 6'(r);
    if (r == 7) return NONE;
    return 6'($urandom_range(cn, 62));
  endfunction

  function automatic logic [W+5:0] wrong_rsp(input int j);
    logic [5:0] idx;
    idx = 6'($urandom_range(0, 63));
    if (idx == 6'(j)) idx = NONE;
    return {idx, 16'($urandom)};
  endfunction

  task automatic drive_q(input logic [5:0] q);
    cur_q = q;
    case (dut) 0: qry_a = q; 1: qry_b = q; default: qry_c = q; endcase
  endtask

  task automatic drive_rsp(input logic [W+5:0] r);
    case (dut) 0: rsp_a = r; 1: rsp_b = r; default: rsp_c = r; endcase
  endtask

  task automatic drive_rst(input logic v);
    case (dut) 0: rst_a = v; 1: rst_b = v; default: rst_c = v; endcase
  endtask

  task automatic drive_graph(input logic [1:0] id);
    for (int i = 0; i < cn; i++)
      for (int j = 0; j < cn; j++)
        case (dut)
          0: adj_a[i*4+j] = m_adj[i][j];
          1: adj_b[i*4+j] = m_adj[i][j];
          default: adj_c[i*2+j] = m_adj[i][j];
        endcase
    for (int j = 0; j < cn; j++)
      case (dut)
        0: wt_a[j*16 +: 16] = m_w[j];
        1: wt_b[j*16 +: 16] = m_w[j];
        default: wt_c[j*16 +: 16] = m_w[j];
      endcase
    case (dut) 0: id_a = id; 1: id_b = id; default: id_c = id; endcase
    cbase = int'(id) * cm;
  endtask

  task automatic set_dut(input int d);
    drive_rst(1'b1);
    dut = d;
    case (d)
      0: begin cn = 4; cm = 4; citers = 32; end
      1: begin cn = 4; cm = 2; citers = 2; end
      default: begin cn = 2; cm = 2; citers = 3; end
    endcase
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m_adj[i][j] = 1'b0;
  endtask

  task automatic rand_graph();
    int deg;
    for (int i = 0; i < cn; i++)
      for (int j = 0; j < cn; j++) m_adj[i][j] = 1'($urandom_range(0, 1));
    for (int j = 0; j < cn; j++) begin
      deg = 0;
      for (int i = 0; i < cn; i++) deg += int'(m_adj[i][j]);
      m_w[j] = ($urandom_range(0, 1) == 1) ? recip(deg) : 16'($urandom);
    end
  endtask

  // Push the expectation for the coming edge, then advance one clock.
  task automatic step(input bit commit, input bit in_rst, input logic [5:0] ereq);
    exp_t e;
    e.tag = cyc + 1;
    e.d   = dut;
    e.ph  = phase;
    if (in_rst) begin
      for (int i = 0; i < 4; i++) m_rank[i] = recip(cn);
      e.rep = '0;
      e.req = NONE;
    end else begin
      e.rep = is_local(int'(cur_q)) ? m_rank[cur_q[1:0]] : '0;
      if (commit) commit_model();
      e.req = ereq;
    end
    e.n0 = m_rank[cbase];
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive_q(rand_q());
  endtask

  task automatic run_reset(input int k);
    drive_rst(1'b1);
    repeat (k) step(1'b0, 1'b1, NONE);
    drive_rst(1'b0);
  endtask

  task automatic run_iter(input int stop_at);
    for (int j = 0; j < cn; j++) begin
      if (j == stop_at) return;
      if (is_local(j)) begin
        drive_rsp(wrong_rsp(j));
        step(1'b0, 1'b0, NONE);
      end else begin
        int d;
        drive_rsp(wrong_rsp(j));
        step(1'b0, 1'b0, 6'(j));
        d = $urandom_range(0, 3);
        repeat (d) begin
          drive_rsp(wrong_rsp(j));
          step(1'b0, 1'b0, 6'(j));
        end
        m_rem[j] = 16'($urandom);
        drive_rsp({6'(j), m_rem[j]});
        step(1'b0, 1'b0, NONE);
      end
    end
    drive_rsp(wrong_rsp(63));
    step(1'b1, 1'b0, NONE);
  endtask

  task automatic run_done(input int k);
    repeat (k) begin
      drive_rsp(wrong_rsp(63));
      step(1'b0, 1'b0, NONE);
    end
  endtask

  task automatic run_all();
    for (int it = 0; it < citers; it++) run_iter(-1);
  endtask

  // Stimulus
  initial begin
    logic [15:0] ex_adj;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    adj_a = '0; adj_b = '0; adj_c = '0;
    wt_a = '0; wt_b = '0; wt_c = '0;
    id_a = '0; id_b = '0; id_c = '0;
    qry_a = NONE; qry_b = NONE; qry_c = NONE;
    rsp_a = '0; rsp_b = '0; rsp_c = '0;
    cur_q = NONE;
    phase = 0;
    @(posedge clk);
    #1;

    // example graph, full run then DONE hold
    set_dut(0);
    ex_adj = 16'h3B1C;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m_adj[i][j] = ex_adj[i*4+j];
    m_w[0] = 16'h5555; m_w[1] = 16'h8000; m_w[2] = 16'hFFFF; m_w[3] = 16'h8000;
    drive_graph(2'd0);
    phase = 1; run_reset(2); run_all(); run_done(4);

    // reset during second ACCUM, then the sequence repeats
    phase = 2; run_reset(1); run_iter(-1); run_iter(2);
    run_reset(1); run_all(); run_done(2);

    // random graphs and weights
    repeat (3) begin
      phase++;
      rand_graph(); drive_graph(2'd0);
      run_reset(1); run_all(); run_done(2);
    end

    // remote fetch with random stall lengths
    set_dut(1);
    repeat (4) begin
      phase++;
      rand_graph(); drive_graph(2'($urandom_range(0, 1)));
      run_reset(2); run_all(); run_done(3);
    end

    // saturation: fully connected, unit weights
    set_dut(2);
    phase++;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) m_adj[i][j] = 1'b1;
    m_w[0] = 16'hFFFF; m_w[1] = 16'hFFFF;
    drive_graph(2'd0);
    run_reset(2); run_all(); run_done(3);
    repeat (2) begin
      phase++;
      rand_graph(); drive_graph(2'd0);
      run_reset(1); run_all(); run_done(2);
    end

    drive_rst(1'b1);
    repeat (2) @(posedge clk);
    finishing = 1'b1;
  end

  initial begin
    #200000;
    timed_out = 1'b1;
  end

  // Monitor: pop and compare every expectation whose edge has passed.
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] a_n0, a_rep;
    logic [5:0]   a_req;
    while (sb.size() > 0) begin
      if (sb[0].tag > cyc) break;
      e = sb.pop_front();
      case (e.d)
        0: begin a_n0 = n0_a; a_rep = rep_a; a_req = req_a; end
        1: begin a_n0 = n0_b; a_rep = rep_b; a_req = req_b; end
        default: begin a_n0 = n0_c; a_rep = rep_c; a_req = req_c; end
      endcase
      n_vec++;
      if (a_n0 !== e.n0) begin
        n_err++;
        $display("FAIL node0Val dut%0d ph%0d cyc%0d: got %h want %h", e.d, e.ph, e.tag, a_n0, e.n0);
      end
      n_vec++;
      if (a_rep !== e.rep) begin
        n_err++;
        $display("FAIL reply dut%0d ph%0d cyc%0d: got %h want %h", e.d, e.ph, e.tag, a_rep, e.rep);
      end
      n_vec++;
      if (a_req !== e.req) begin
        n_err++;
        $display("FAIL request dut%0d ph%0d cyc%0d: got %h want %h", e.d, e.ph, e.tag, a_req, e.req);
      end
    end
    if (timed_out) begin
      n_err++;
      $display("FAIL watchdog: got %0d pending want 0", sb.size());
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end else if (finishing) begin
      if (sb.size() > 0) begin
        n_err++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

endmodule
